// File: rtl/keypad_entry_pkg.sv
// Shared definitions for the keypad entry block: debounce FSM states,
// special key codes and the width of the BCD entry register.
package keypad_entry_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_CLR     = 4'ha;
    localparam logic [3:0] KEY_BS      = 4'hb;
    localparam logic [3:0] KEY_ENT_MIN = 4'hc;
    localparam int         NUM_DIGITS  = 4;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Window-based press/release debouncer: one 4-cycle scan window covers every
// row once, so a window either saw the key or it did not.
module keypad_debounce
    import keypad_entry_pkg::*;
#(
    parameter int DEBOUNCE_WIN = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] keypad_col_i,
    input  logic [3:0] keypad_buf_i,
    output logic       key_valid_o,
    output logic [3:0] key_code_o
);

    localparam logic [3:0] WIN_TARGET = 4'(DEBOUNCE_WIN);

    logic [1:0] win_cnt_q;
    logic       hit_acc_q;
    kp_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic [3:0] code_q;

    logic       hit;
    logic       win_end;
    logic       win_hit;
    logic [3:0] cnt_inc;

    assign hit     = (keypad_col_i != 4'b1111);
    assign win_end = (win_cnt_q == 2'd3);
    // The last cycle of a window is folded in directly instead of waiting for the accumulator.
    assign win_hit = hit_acc_q | hit;
    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (win_end) begin
            case (state_q)
                IDLE: begin
                    if (win_hit) begin
                        state_d = PRESS_DB;
                        cnt_d   = 4'd1;
                    end
                end
                PRESS_DB: begin
                    if (!win_hit) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else if (cnt_inc == WIN_TARGET) begin
                        state_d = PRESSED;
                        cnt_d   = 4'd0;
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                PRESSED: begin
                    if (!win_hit) begin
                        state_d = REL_DB;
                        cnt_d   = 4'd1;
                    end
                end
                REL_DB: begin
                    if (win_hit) begin
                        state_d = PRESSED;
                        cnt_d   = 4'd0;
                    end else if (cnt_inc == WIN_TARGET) begin
                        state_d = IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= 2'd0;
            hit_acc_q <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            valid_q   <= 1'b0;
            code_q    <= 4'd0;
        end else begin
            win_cnt_q <= win_cnt_q + 2'd1;
            hit_acc_q <= win_end ? 1'b0 : (hit_acc_q | hit);
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            if (valid_d) begin
                code_q <= keypad_buf_i;
            end
        end
    end

    assign key_valid_o = valid_q;
    assign key_code_o  = code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounced key events feed a 4-digit BCD entry register
// with clear, backspace and enter.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int DEBOUNCE_WIN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  keypadCol,
    input  logic [3:0]  keypadBuf,
    output logic        keyValid,
    output logic [3:0]  keyCode,
    output logic [15:0] digits,
    output logic [2:0]  digitCount,
    output logic [15:0] entered,
    output logic        enterPulse
);

    logic [15:0] digits_q, digits_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] entered_q, entered_d;
    logic        ent_pulse_q, ent_pulse_d;

    keypad_debounce #(
        .DEBOUNCE_WIN (DEBOUNCE_WIN)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (reset),
        .keypad_col_i (keypadCol),
        .keypad_buf_i (keypadBuf),
        .key_valid_o  (keyValid),
        .key_code_o   (keyCode)
    );

    always_comb begin
        digits_d    = digits_q;
        count_d     = count_q;
        entered_d   = entered_q;
        ent_pulse_d = 1'b0;
        if (keyValid) begin
            if (is_digit(keyCode)) begin
                // A full register ignores further digits rather than scrolling.
                if (count_q < 3'(NUM_DIGITS)) begin
                    digits_d = {digits_q[11:0], keyCode};
                    count_d  = count_q + 3'd1;
                end
            end else if (keyCode == KEY_CLR) begin
                digits_d = 16'h0000;
                count_d  = 3'd0;
            end else if (keyCode == KEY_BS) begin
                if (count_q != 3'd0) begin
                    digits_d = {4'h0, digits_q[15:4]};
                    count_d  = count_q - 3'd1;
                end
            end else if (keyCode >= KEY_ENT_MIN) begin
                entered_d   = digits_q;
                ent_pulse_d = 1'b1;
                digits_d    = 16'h0000;
                count_d     = 3'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digits_q    <= 16'h0000;
            count_q     <= 3'd0;
            entered_q   <= 16'h0000;
            ent_pulse_q <= 1'b0;
        end else begin
            digits_q    <= digits_d;
            count_q     <= count_d;
            entered_q   <= entered_d;
            ent_pulse_q <= ent_pulse_d;
        end
    end

    assign digits     = digits_q;
    assign digitCount = count_q;
    assign entered    = entered_q;
    assign enterPulse = ent_pulse_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: a row-scanner model drives the column
// lines window by window and a run-length/queue reference model predicts the outputs.
module tb_keypad_entry;

    localparam int DW = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  keypadCol;
    logic [3:0]  keypadBuf;
    logic        keyValid;
    logic [3:0]  keyCode;
    logic [15:0] digits;
    logic [2:0]  digitCount;
    logic [15:0] entered;
    logic        enterPulse;

    always #5 clk = ~clk;

    keypad_entry #(
        .DEBOUNCE_WIN (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keypadCol  (keypadCol),
        .keypadBuf  (keypadBuf),
        .keyValid   (keyValid),
        .keyCode    (keyCode),
        .digits     (digits),
        .digitCount (digitCount),
        .entered    (entered),
        .enterPulse (enterPulse)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: press accepted after DW consecutive hit windows while armed;
    // re-armed after DW consecutive empty windows. Entry is a queue of digits.
    bit          armed;
    int          hit_run;
    int          miss_run;
    int          dq[$];
    logic [15:0] m_entered;
    bit          exp_valid;
    logic [3:0]  exp_code;
    bit          exp_enter;
    int          events_seen;
    int          enters_seen;

    bit          prev_hit;
    logic [3:0]  prev_key;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] packed_digits();
        logic [15:0] v;
        v = 16'h0000;
        foreach (dq[i]) v = {v[11:0], 4'(dq[i])};
        return v;
    endfunction

    task automatic apply_entry(input logic [3:0] code);
        if (code <= 4'd9) begin
            if (dq.size() < 4) dq.push_back(int'(code));
        end else if (code == 4'ha) begin
            dq.delete();
        end else if (code == 4'hb) begin
            if (dq.size() > 0) void'(dq.pop_back());
        end else begin
            m_entered = packed_digits();
            exp_enter = 1'b1;
            dq.delete();
        end
    endtask

    task automatic model_window(input bit hit, input logic [3:0] key);
        exp_valid = 1'b0;
        exp_enter = 1'b0;
        if (hit) begin
            hit_run++;
            miss_run = 0;
        end else begin
            miss_run++;
            hit_run = 0;
        end
        if (armed && hit_run >= DW) begin
            armed     = 1'b0;
            exp_valid = 1'b1;
            exp_code  = key;
            apply_entry(key);
        end else if (!armed && miss_run >= DW) begin
            armed = 1'b1;
        end
    endtask

    // One scan window: row c is driven in cycle c; the key is seen only on its own row.
    task automatic do_window(input bit hit, input logic [3:0] key);
        logic [3:0] one;
        logic [1:0] krow;
        logic [1:0] kcol;
        one  = 4'b0001;
        krow = key[3:2];
        kcol = key[1:0];
        for (int c = 0; c < 4; c++) begin
            if (prev_hit) keypadBuf = prev_key;
            keypadCol = (hit && krow == 2'(c)) ? ~(one << kcol) : 4'b1111;
            prev_hit  = (keypadCol != 4'b1111);
            prev_key  = key;
            @(negedge clk);
            check_eq("keyValid", keyValid, (c == 0) && exp_valid);
            if (keyValid) events_seen++;
            if (enterPulse) enters_seen++;
            if (c == 0 && exp_valid) check_eq("keyCode", keyCode, exp_code);
            check_eq("enterPulse", enterPulse, (c == 1) && exp_enter);
            if (c == 2) begin
                check_eq("digits", digits, packed_digits());
                check_eq("digitCount", digitCount, dq.size());
                check_eq("entered", entered, m_entered);
            end
            @(posedge clk);
            #1;
        end
        model_window(hit, key);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_keyValid", keyValid, 0);
        check_eq("rst_keyCode", keyCode, 0);
        check_eq("rst_digits", digits, 0);
        check_eq("rst_digitCount", digitCount, 0);
        check_eq("rst_entered", entered, 0);
        check_eq("rst_enterPulse", enterPulse, 0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        armed     = 1'b1;
        hit_run   = 0;
        miss_run  = 0;
        dq.delete();
        m_entered = 16'h0000;
        exp_valid = 1'b0;
        exp_enter = 1'b0;
    endtask

    task automatic press(input logic [3:0] key, input int hold);
        repeat (hold) do_window(1'b1, key);
        repeat (DW + 2) do_window(1'b0, key);
    endtask

    initial begin
        int ev0;
        int en0;
        reset       = 1'b0;
        keypadCol   = 4'b1111;
        keypadBuf   = 4'h0;
        prev_hit    = 1'b0;
        prev_key    = 4'h0;
        events_seen = 0;
        enters_seen = 0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // Held key yields one event only
        ev0 = events_seen;
        press(4'h5, 40);
        check_eq("t1_events", events_seen - ev0, 1);
        check_eq("t1_digits", digits, 16'h0005);
        check_eq("t1_count", digitCount, 1);

        // Fill the register, then overflow digit is ignored
        press(4'ha, DW + 1);
        press(4'h1, DW + 1);
        press(4'h2, DW + 1);
        press(4'h3, DW + 1);
        press(4'h4, DW + 1);
        check_eq("t2_digits", digits, 16'h1234);
        check_eq("t2_count", digitCount, 4);
        ev0 = events_seen;
        press(4'h5, DW + 1);
        check_eq("t2_fifth_event", events_seen - ev0, 1);
        check_eq("t2_digits_kept", digits, 16'h1234);

        // Backspace then enter
        press(4'ha, DW + 1);
        press(4'h7, DW + 1);
        press(4'h8, DW + 1);
        press(4'hb, DW + 1);
        check_eq("t3_digits", digits, 16'h0007);
        check_eq("t3_count", digitCount, 1);
        en0 = enters_seen;
        press(4'hc, DW + 1);
        check_eq("t3_enters", enters_seen - en0, 1);
        check_eq("t3_entered", entered, 16'h0007);
        check_eq("t3_digits_clr", digits, 16'h0000);

        // Bounce on press and on release
        ev0 = events_seen;
        repeat (3) begin
            do_window(1'b1, 4'h9);
            do_window(1'b0, 4'h9);
        end
        repeat (DW) do_window(1'b1, 4'h9);
        do_window(1'b0, 4'h9);
        do_window(1'b1, 4'h9);
        do_window(1'b0, 4'h9);
        do_window(1'b1, 4'h9);
        repeat (DW + 2) do_window(1'b0, 4'h9);
        check_eq("t4_events", events_seen - ev0, 1);
        check_eq("t4_digits", digits, 16'h0009);

        // Clear and backspace at empty register
        press(4'h1, DW + 1);
        press(4'h2, DW + 1);
        en0 = enters_seen;
        press(4'ha, DW + 1);
        check_eq("t5_digits", digits, 16'h0000);
        check_eq("t5_count", digitCount, 0);
        check_eq("t5_enters", enters_seen - en0, 0);
        press(4'hb, DW + 1);
        check_eq("t5_bs_empty", digits, 16'h0000);
        check_eq("t5_bs_count", digitCount, 0);

        // Enter on an empty register still pulses with zero
        en0 = enters_seen;
        press(4'hf, DW + 1);
        check_eq("t5_empty_enter", enters_seen - en0, 1);
        check_eq("t5_entered_zero", entered, 16'h0000);

        // Reset while a key is held; it must debounce again afterwards
        press(4'h6, DW + 1);
        repeat (DW + 2) do_window(1'b1, 4'h3);
        do_reset();
        ev0 = events_seen;
        repeat (DW + 2) do_window(1'b1, 4'h3);
        repeat (DW + 2) do_window(1'b0, 4'h3);
        check_eq("t6_events", events_seen - ev0, 1);
        check_eq("t6_digits", digits, 16'h0003);

        // Randomized episodes: bounce, hold, glitchy release, idle
        for (int ep = 0; ep < 30; ep++) begin
            logic [3:0] k;
            k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            repeat ($urandom_range(0, 2)) begin
                do_window(1'b1, k);
                do_window(1'b0, k);
            end
            repeat ($urandom_range(DW - 1, DW + 6)) do_window(1'b1, k);
            repeat ($urandom_range(0, 2)) begin
                do_window(1'b0, k);
                do_window(($urandom_range(0, 1) == 1), k);
            end
            repeat ($urandom_range(1, DW + 2)) do_window(1'b0, k);
        end
        repeat (DW + 2) do_window(1'b0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
